// File: rtl/fetch_pkg.sv
// Shared widths, constants and FSM encoding for the instruction fetch slice.
package fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_UNUSED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: small power-of-two FIFO of {pc, instruction} with flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  logic [ILEN-1:0]         wr_instr_i,
    input  logic [XLEN-1:0]         wr_pc_i,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    valid_o,
    output logic [ILEN-1:0]         head_instr_o,
    output logic [XLEN-1:0]         head_pc_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ILEN-1:0]  instr_q [DEPTH];
    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;
    logic             push_ok;

    // Flush wins over both ends so a popped entry in a flush cycle is simply lost.
    assign pop_ok  = pop_i && (count_q != '0) && !flush_i;
    assign push_ok = push_i && !flush_i;

    always_comb begin
        rd_d    = pop_ok  ? rd_q + 1'b1 : rd_q;
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset || flush_i) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            instr_q[wr_q] <= wr_instr_i;
            pc_q[wr_q]    <= wr_pc_i;
        end
    end

    // Empty buffer presents a NOP at pc 0 so storage never needs a reset.
    assign count_o      = count_q;
    assign valid_o      = (count_q != '0);
    assign head_instr_o = valid_o ? instr_q[rd_q] : NOP_INSTR;
    assign head_pc_o    = valid_o ? pc_q[rd_q] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, run/halt FSM and redirect handling in front of a fetch buffer.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic            CLK,
    input  logic            reset,
    output logic [XLEN-1:0] PC,
    input  logic            icache_r,
    input  logic [ILEN-1:0] instruction,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    input  logic            dec_ready,
    output logic            dec_valid,
    output logic [ILEN-1:0] dec_instr,
    output logic [XLEN-1:0] dec_pc,
    output logic [1:0]      fetch_state
);

    localparam int               CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    fetch_state_e     state_q;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] count;
    logic             pop;
    logic             push;
    logic             unused_rpc_bits;

    assign unused_rpc_bits = ^redirect_pc[1:0];

    assign pop  = dec_valid && dec_ready;
    assign push = (state_q == ST_RUN) && icache_r && !redirect_valid && !halt &&
                  ((count < DEPTH_C) || pop);

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid)
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        else if (push)
            pc_d = pc_q + 64'd4;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            pc_q <= pc_d;
            if (redirect_valid) begin
                state_q <= ST_RUN;
            end else begin
                case (state_q)
                    ST_IDLE:   state_q <= ST_RUN;
                    ST_RUN:    state_q <= halt ? ST_HALTED : ST_RUN;
                    ST_HALTED: state_q <= ST_HALTED;
                    default:   state_q <= ST_IDLE;
                endcase
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK          (CLK),
        .reset        (reset),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (redirect_valid),
        .wr_instr_i   (instruction),
        .wr_pc_i      (pc_q),
        .count_o      (count),
        .valid_o      (dec_valid),
        .head_instr_o (dec_instr),
        .head_pc_o    (dec_pc)
    );

    assign PC          = pc_q;
    assign fetch_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based reference model, plus directed scenarios.
module tb_fetch_stage;

    localparam logic [63:0] RPC   = 64'h0;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] PC;
    logic        icache_r = 1'b0;
    logic [31:0] instruction = '0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        dec_ready = 1'b0;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [63:0] dec_pc;
    logic [1:0]  fetch_state;

    fetch_stage #(
        .RESET_PC   (RPC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .CLK            (CLK),
        .reset          (reset),
        .PC             (PC),
        .icache_r       (icache_r),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .dec_ready      (dec_ready),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_pc         (dec_pc),
        .fetch_state    (fetch_state)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [63:0] m_pc = '0;
    int          m_st = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Reference: one clock of behaviour, from the current model and current inputs.
    task automatic model_step();
        bit pop, push;
        if (reset) begin
            m_pc = RPC;
            m_st = 0;
            mq.delete();
        end else if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc & ~64'd3;
            m_st = 1;
        end else begin
            pop  = (mq.size() > 0) && dec_ready;
            push = (m_st == 1) && icache_r && !halt && ((mq.size() < DEPTH) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back('{pc: m_pc, instr: instruction});
                m_pc = m_pc + 64'd4;
            end
            if (m_st == 0) m_st = 1;
            else if (m_st == 1 && halt) m_st = 2;
        end
    endtask

    task automatic compare_all();
        check("pc", PC, m_pc);
        check("state", {62'd0, fetch_state}, 64'(m_st));
        check("dec_valid", {63'd0, dec_valid}, {63'd0, mq.size() > 0});
        if (mq.size() > 0) begin
            check("dec_pc", dec_pc, mq[0].pc);
            check("dec_instr", {32'd0, dec_instr}, {32'd0, mq[0].instr});
        end
    endtask

    task automatic cyc(input bit rst, input bit icr, input bit rv, input logic [63:0] rpc,
                       input bit hlt, input bit rdy);
        reset          = rst;
        icache_r       = icr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = hlt;
        dec_ready      = rdy;
        instruction    = $urandom;
        model_step();
        @(posedge CLK);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 64'h55, 1, 1);
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_pc", PC, RPC);
        check("rst_state", {62'd0, fetch_state}, 64'd0);
        check("rst_valid", {63'd0, dec_valid}, 64'd0);
        check("rst_instr", {32'd0, dec_instr}, {32'd0, NOP});
        check("rst_decpc", dec_pc, 64'd0);

        // Streaming with decode always ready
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0, 0, 1);

        // Decode stalls: buffer fills after two pushes, PC parks at 8
        do_reset();
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 0);
        check("stall_pc", PC, 64'h8);
        check("stall_decpc", dec_pc, 64'h0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 1);

        // Cache miss holds PC
        cyc(0, 1, 1, 64'h10, 0, 1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1);
        check("miss_pc", PC, 64'h10);
        check("miss_valid", {63'd0, dec_valid}, 64'd0);
        cyc(0, 1, 0, 0, 0, 1);
        check("miss_resume_decpc", dec_pc, 64'h10);

        // Redirect flushes two buffered entries and aligns the target
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 64'h103, 0, 1);
        check("redir_valid", {63'd0, dec_valid}, 64'd0);
        check("redir_pc", PC, 64'h100);
        cyc(0, 1, 0, 0, 0, 1);
        check("redir_decpc", dec_pc, 64'h100);

        // Halt with one entry buffered, drain, then redirect out
        cyc(0, 1, 0, 0, 1, 0);
        check("halt_state", {62'd0, fetch_state}, 64'd2);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 1);
        check("halt_pc_frozen", PC, 64'h104);
        cyc(0, 1, 1, 64'h40, 0, 1);
        check("unhalt_state", {62'd0, fetch_state}, 64'd1);
        check("unhalt_pc", PC, 64'h40);
        cyc(0, 1, 0, 0, 0, 1);

        // PC wraps at the top of the address space
        cyc(0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
        check("wrap_pre", PC, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(0, 1, 0, 0, 0, 1);
        check("wrap_pc", PC, 64'h0);

        // Full buffer push+pop, then reset mid-stream
        do_reset();
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1);
        check("full_pushpop_pc", PC, 64'hC);
        cyc(1, 1, 0, 0, 0, 1);
        check("mid_rst_pc", PC, RPC);
        check("mid_rst_valid", {63'd0, dec_valid}, 64'd0);
        check("mid_rst_instr", {32'd0, dec_instr}, {32'd0, NOP});

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 15) == 0),
                {$urandom, $urandom},
                ($urandom_range(0, 19) == 0),
                $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
